// File: rtl/mode_ctrl_pkg.sv
// Shared mode codes, FSM state encoding and field-select constants for the
// clock/timer/stopwatch mode controller.
package mode_ctrl_pkg;

  localparam logic [1:0] MODE_TIMER     = 2'b00;
  localparam logic [1:0] MODE_STOPWATCH = 2'b01;
  localparam logic [1:0] MODE_CLK12     = 2'b10;
  localparam logic [1:0] MODE_CLK24     = 2'b11;

  typedef enum logic [2:0] {
    ST_DISPLAY  = 3'd0,
    ST_SET_HOUR = 3'd1,
    ST_SET_MIN  = 3'd2,
    ST_SET_SEC  = 3'd3,
    ST_ALARM    = 3'd4
  } state_t;

  localparam logic [2:0] FIELD_NONE = 3'b000;
  localparam logic [2:0] FIELD_HOUR = 3'b100;
  localparam logic [2:0] FIELD_MIN  = 3'b010;
  localparam logic [2:0] FIELD_SEC  = 3'b001;

endpackage

// File: rtl/btn_edge.sv
// Registers a debounced button level and flags the first cycle it is high.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic btn_p0;

  always_ff @(posedge clk) begin
    if (rst) btn_p0 <= 1'b0;
    else     btn_p0 <= btn;
  end

  assign press = btn & ~btn_p0;

endmodule

// File: rtl/mode_controller.sv
// Mode/set/alarm control FSM: display select, run enables, field setting
// sequence and timer-expiry alarm with auto-dismiss.
module mode_controller
  import mode_ctrl_pkg::*;
#(
  parameter int ALARM_SECS = 10
) (
  input  logic       clk_100MHz,
  input  logic       resetn,
  input  logic       tick_1Hz,
  input  logic       mode_btn,
  input  logic       set_btn,
  input  logic       inc_btn,
  input  logic       start_stop_btn,
  input  logic       timer_zero,
  output logic [1:0] sel,
  output logic       run_timer,
  output logic       run_stopwatch,
  output logic       run_clock,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       inc_sec,
  output logic [1:0] inc_target,
  output logic       clear_stopwatch,
  output logic [2:0] field_sel,
  output logic       alarm
);

  localparam logic [5:0] ALARM_LAST = 6'(ALARM_SECS - 1);

  logic mode_press, set_press, inc_press, ss_press, any_press, expire;

  btn_edge u_mode (.clk(clk_100MHz), .rst(resetn), .btn(mode_btn),       .press(mode_press));
  btn_edge u_set  (.clk(clk_100MHz), .rst(resetn), .btn(set_btn),        .press(set_press));
  btn_edge u_inc  (.clk(clk_100MHz), .rst(resetn), .btn(inc_btn),        .press(inc_press));
  btn_edge u_ss   (.clk(clk_100MHz), .rst(resetn), .btn(start_stop_btn), .press(ss_press));

  assign any_press = mode_press | set_press | inc_press | ss_press;
  assign expire    = run_timer & timer_zero & tick_1Hz;

  state_t     state, state_nx;
  logic [1:0] sel_nx;
  logic       run_timer_nx, run_stopwatch_nx, run_clock_nx;
  logic       inc_hour_nx, inc_min_nx, inc_sec_nx, clear_nx;
  logic [2:0] field_sel_nx;
  logic       alarm_nx, alarm_pending, alarm_pending_nx;
  logic [5:0] alarm_cnt, alarm_cnt_nx;

  always_ff @(posedge clk_100MHz) begin
    if (resetn) begin
      state           <= ST_DISPLAY;
      sel             <= MODE_TIMER;
      run_timer       <= 1'b0;
      run_stopwatch   <= 1'b0;
      run_clock       <= 1'b1;
      inc_hour        <= 1'b0;
      inc_min         <= 1'b0;
      inc_sec         <= 1'b0;
      clear_stopwatch <= 1'b0;
      field_sel       <= FIELD_NONE;
      alarm           <= 1'b0;
      alarm_cnt       <= 6'd0;
      alarm_pending   <= 1'b0;
    end else begin
      state           <= state_nx;
      sel             <= sel_nx;
      run_timer       <= run_timer_nx;
      run_stopwatch   <= run_stopwatch_nx;
      run_clock       <= run_clock_nx;
      inc_hour        <= inc_hour_nx;
      inc_min         <= inc_min_nx;
      inc_sec         <= inc_sec_nx;
      clear_stopwatch <= clear_nx;
      field_sel       <= field_sel_nx;
      alarm           <= alarm_nx;
      alarm_cnt       <= alarm_cnt_nx;
      alarm_pending   <= alarm_pending_nx;
    end
  end

  always_comb begin
    state_nx         = state;
    sel_nx           = sel;
    run_timer_nx     = run_timer;
    run_stopwatch_nx = run_stopwatch;
    run_clock_nx     = run_clock;
    inc_hour_nx      = 1'b0;
    inc_min_nx       = 1'b0;
    inc_sec_nx       = 1'b0;
    clear_nx         = 1'b0;
    field_sel_nx     = field_sel;
    alarm_nx         = alarm;
    alarm_cnt_nx     = alarm_cnt;
    alarm_pending_nx = alarm_pending;

    if (expire) run_timer_nx = 1'b0;

    unique case (state)
      ST_DISPLAY: begin
        // Presses are evaluated in priority order; the first match wins.
        if (expire) begin
          state_nx     = ST_ALARM;
          alarm_nx     = 1'b1;
          alarm_cnt_nx = 6'd0;
        end else if (set_press) begin
          if ((sel == MODE_TIMER && !run_timer) || sel[1]) begin
            state_nx     = ST_SET_HOUR;
            field_sel_nx = FIELD_HOUR;
            if (sel[1]) run_clock_nx = 1'b0;
          end else if (sel == MODE_STOPWATCH && !run_stopwatch) begin
            clear_nx = 1'b1;
          end
        end else if (ss_press) begin
          if (sel == MODE_TIMER) begin
            if (run_timer)        run_timer_nx = 1'b0;
            else if (!timer_zero) run_timer_nx = 1'b1;
          end else if (sel == MODE_STOPWATCH) begin
            run_stopwatch_nx = ~run_stopwatch;
          end
        end else if (mode_press) begin
          sel_nx = sel + 2'd1;
        end
      end
      ST_SET_HOUR, ST_SET_MIN, ST_SET_SEC: begin
        if (expire) alarm_pending_nx = 1'b1;
        if (set_press) begin
          case (state)
            ST_SET_HOUR: begin
              state_nx     = ST_SET_MIN;
              field_sel_nx = FIELD_MIN;
            end
            ST_SET_MIN: begin
              state_nx     = ST_SET_SEC;
              field_sel_nx = FIELD_SEC;
            end
            default: begin
              run_clock_nx = 1'b1;
              field_sel_nx = FIELD_NONE;
              // An expiry seen while setting (including this cycle) fires now.
              if (alarm_pending || expire) begin
                state_nx         = ST_ALARM;
                alarm_nx         = 1'b1;
                alarm_cnt_nx     = 6'd0;
                alarm_pending_nx = 1'b0;
              end else begin
                state_nx = ST_DISPLAY;
              end
            end
          endcase
        end else if (inc_press) begin
          inc_hour_nx = (state == ST_SET_HOUR);
          inc_min_nx  = (state == ST_SET_MIN);
          inc_sec_nx  = (state == ST_SET_SEC);
        end
      end
      ST_ALARM: begin
        if (any_press || (tick_1Hz && alarm_cnt == ALARM_LAST)) begin
          state_nx     = ST_DISPLAY;
          alarm_nx     = 1'b0;
          alarm_cnt_nx = 6'd0;
        end else if (tick_1Hz) begin
          alarm_cnt_nx = alarm_cnt + 6'd1;
        end
      end
      default: state_nx = ST_DISPLAY;
    endcase
  end

  assign inc_target = sel;

endmodule

// File: tb/tb_mode_controller.sv
// Self-checking bench for mode_controller: directed scenarios plus randomized
// traffic compared cycle-by-cycle against a behavioural model.
module tb_mode_controller;

  localparam int ALARM_SECS = 10;
  localparam logic [3:0] B_NONE = 4'b0000;
  localparam logic [3:0] B_MODE = 4'b1000;
  localparam logic [3:0] B_SET  = 4'b0100;
  localparam logic [3:0] B_SS   = 4'b0010;
  localparam logic [3:0] B_INC  = 4'b0001;
  localparam logic [14:0] RESET_VEC = 15'b00_0_0_1_000_00_0_000_0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn, tick, mode_b, set_b, inc_b, ss_b, tz;
  logic [1:0] sel, inc_target;
  logic run_timer, run_stopwatch, run_clock, inc_hour, inc_min, inc_sec;
  logic clear_stopwatch, alarm;
  logic [2:0] field_sel;

  int checks = 0;
  int failures = 0;

  mode_controller #(.ALARM_SECS(ALARM_SECS)) dut (
    .clk_100MHz(clk), .resetn(resetn), .tick_1Hz(tick),
    .mode_btn(mode_b), .set_btn(set_b), .inc_btn(inc_b),
    .start_stop_btn(ss_b), .timer_zero(tz),
    .sel(sel), .run_timer(run_timer), .run_stopwatch(run_stopwatch),
    .run_clock(run_clock), .inc_hour(inc_hour), .inc_min(inc_min),
    .inc_sec(inc_sec), .inc_target(inc_target),
    .clear_stopwatch(clear_stopwatch), .field_sel(field_sel), .alarm(alarm)
  );

  // Behavioural model: mode index, field being set (0 none, 1 hour, 2 min,
  // 3 sec), alarm flag with elapsed tick count, and last seen button levels.
  int m_sel, m_field, m_ticks;
  bit m_rt, m_rs, m_rc, m_ih, m_im, m_is, m_clr, m_alarm, m_pend;
  bit pv_mode, pv_set, pv_inc, pv_ss;

  task automatic model_step();
    bit p_mode, p_set, p_inc, p_ss, expire;
    if (resetn) begin
      m_sel = 0; m_field = 0; m_ticks = 0;
      m_rt = 0; m_rs = 0; m_rc = 1; m_ih = 0; m_im = 0; m_is = 0;
      m_clr = 0; m_alarm = 0; m_pend = 0;
      pv_mode = 0; pv_set = 0; pv_inc = 0; pv_ss = 0;
      return;
    end
    p_mode = mode_b && !pv_mode; p_set = set_b && !pv_set;
    p_inc = inc_b && !pv_inc;    p_ss = ss_b && !pv_ss;
    pv_mode = mode_b; pv_set = set_b; pv_inc = inc_b; pv_ss = ss_b;
    m_ih = 0; m_im = 0; m_is = 0; m_clr = 0;
    expire = m_rt && tz && tick;
    if (expire) m_rt = 0;
    if (m_alarm) begin
      if (p_mode || p_set || p_inc || p_ss || (tick && m_ticks == ALARM_SECS - 1)) begin
        m_alarm = 0; m_ticks = 0;
      end else if (tick) m_ticks++;
    end else if (m_field != 0) begin
      if (expire) m_pend = 1;
      if (p_set) begin
        m_field++;
        if (m_field == 4) begin
          m_field = 0; m_rc = 1;
          if (m_pend) begin m_alarm = 1; m_ticks = 0; m_pend = 0; end
        end
      end else if (p_inc) begin
        m_ih = (m_field == 1); m_im = (m_field == 2); m_is = (m_field == 3);
      end
    end else begin
      if (expire) begin
        m_alarm = 1; m_ticks = 0;
      end else if (p_set) begin
        if ((m_sel == 0 && !m_rt) || m_sel >= 2) begin
          m_field = 1;
          if (m_sel >= 2) m_rc = 0;
        end else if (m_sel == 1 && !m_rs) m_clr = 1;
      end else if (p_ss) begin
        if (m_sel == 0) begin
          if (m_rt) m_rt = 0;
          else if (!tz) m_rt = 1;
        end else if (m_sel == 1) m_rs = !m_rs;
      end else if (p_mode) m_sel = (m_sel + 1) % 4;
    end
  endtask

  function automatic logic [14:0] model_vec();
    return {2'(m_sel), m_rt, m_rs, m_rc, m_ih, m_im, m_is, 2'(m_sel), m_clr,
            m_field == 1, m_field == 2, m_field == 3, m_alarm};
  endfunction

  function automatic logic [14:0] dut_vec();
    return {sel, run_timer, run_stopwatch, run_clock, inc_hour, inc_min, inc_sec,
            inc_target, clear_stopwatch, field_sel, alarm};
  endfunction

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] b);
    {mode_b, set_b, ss_b, inc_b} = b;
    step();
  endtask

  task automatic do_reset();
    resetn = 1'b1; tick = 1'b0; tz = 1'b0;
    {mode_b, set_b, ss_b, inc_b} = B_NONE;
    step(); step();
    resetn = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (sel !== 2'b00) begin failures++; $display("FAIL reset_sel got=%b exp=00", sel); end
    checks++; if (run_clock !== 1'b1) begin failures++; $display("FAIL reset_run_clock got=%b exp=1", run_clock); end
    checks++; if (field_sel !== 3'b000) begin failures++; $display("FAIL reset_field got=%b exp=000", field_sel); end
    checks++; if (dut_vec() !== RESET_VEC) begin failures++; $display("FAIL reset_all got=%h exp=%h", dut_vec(), RESET_VEC); end
  endtask

  task automatic test_mode_cycle();
    logic [1:0] exp_sel [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(B_MODE);
      checks++;
      if (sel !== exp_sel[i] || run_clock !== 1'b1) begin
        failures++; $display("FAIL mode_cycle%0d got sel=%b rc=%b exp sel=%b rc=1", i, sel, run_clock, exp_sel[i]);
      end
      drive(B_MODE);
      checks++;
      if (sel !== exp_sel[i]) begin failures++; $display("FAIL mode_hold%0d got=%b exp=%b", i, sel, exp_sel[i]); end
      drive(B_NONE);
    end
  endtask

  task automatic test_set_clock();
    int cnt;
    do_reset();
    drive(B_MODE); drive(B_NONE); drive(B_MODE); drive(B_NONE);
    checks++; if (sel !== 2'b10) begin failures++; $display("FAIL set_sel got=%b exp=10", sel); end
    drive(B_SET);
    checks++;
    if (field_sel !== 3'b100 || run_clock !== 1'b0) begin
      failures++; $display("FAIL set_hour got fs=%b rc=%b exp fs=100 rc=0", field_sel, run_clock);
    end
    drive(B_NONE);
    cnt = 0;
    drive(B_INC); cnt += int'(inc_hour);
    checks++; if (inc_hour !== 1'b1) begin failures++; $display("FAIL inc_hour_pulse got=%b exp=1", inc_hour); end
    drive(B_INC); cnt += int'(inc_hour);
    drive(B_NONE); cnt += int'(inc_hour);
    checks++; if (cnt != 1) begin failures++; $display("FAIL inc_hour_count got=%0d exp=1", cnt); end
    drive(B_SET);
    checks++; if (field_sel !== 3'b010) begin failures++; $display("FAIL set_min got=%b exp=010", field_sel); end
    drive(B_NONE);
    cnt = 0;
    for (int i = 0; i < 2; i++) begin
      for (int h = 0; h <= i + 1; h++) begin drive(B_INC); cnt += int'(inc_min) + int'(inc_hour) + int'(inc_sec); end
      drive(B_NONE); cnt += int'(inc_min);
    end
    checks++; if (cnt != 2) begin failures++; $display("FAIL inc_min_count got=%0d exp=2", cnt); end
    drive(B_SET);
    checks++; if (field_sel !== 3'b001) begin failures++; $display("FAIL set_sec got=%b exp=001", field_sel); end
    drive(B_NONE);
    drive(B_SET);
    checks++;
    if (field_sel !== 3'b000 || run_clock !== 1'b1 || sel !== 2'b10) begin
      failures++; $display("FAIL set_done got fs=%b rc=%b sel=%b exp fs=000 rc=1 sel=10", field_sel, run_clock, sel);
    end
    drive(B_NONE);
  endtask

  task automatic test_timer_alarm();
    int dismiss_at;
    do_reset();
    drive(B_SS);
    checks++; if (run_timer !== 1'b1) begin failures++; $display("FAIL timer_start got=%b exp=1", run_timer); end
    drive(B_NONE);
    tz = 1'b1; tick = 1'b1; step(); tick = 1'b0;
    checks++;
    if (run_timer !== 1'b0 || alarm !== 1'b1) begin
      failures++; $display("FAIL timer_expire got rt=%b alarm=%b exp rt=0 alarm=1", run_timer, alarm);
    end
    dismiss_at = -1;
    for (int k = 1; k <= 20 && dismiss_at < 0; k++) begin
      tick = 1'b1; step(); tick = 1'b0;
      if (alarm === 1'b0) dismiss_at = k;
      step(); step();
    end
    checks++; if (dismiss_at != ALARM_SECS) begin failures++; $display("FAIL alarm_ticks got=%0d exp=%0d", dismiss_at, ALARM_SECS); end
    drive(B_SS);
    checks++; if (run_timer !== 1'b0) begin failures++; $display("FAIL start_at_zero got=%b exp=0", run_timer); end
    drive(B_NONE);
    tz = 1'b0;
  endtask

  task automatic test_alarm_dismiss();
    do_reset();
    drive(B_SS); drive(B_NONE);
    drive(B_MODE); drive(B_NONE);
    tz = 1'b1; tick = 1'b1; step(); tick = 1'b0;
    checks++;
    if (alarm !== 1'b1 || sel !== 2'b01 || run_timer !== 1'b0) begin
      failures++; $display("FAIL bg_expire got alarm=%b sel=%b rt=%b exp alarm=1 sel=01 rt=0", alarm, sel, run_timer);
    end
    step();
    drive(B_MODE);
    checks++;
    if (alarm !== 1'b0 || sel !== 2'b01) begin
      failures++; $display("FAIL dismiss got alarm=%b sel=%b exp alarm=0 sel=01", alarm, sel);
    end
    drive(B_NONE);
    checks++; if (sel !== 2'b01) begin failures++; $display("FAIL dismiss_consumed got=%b exp=01", sel); end
    tz = 1'b0;
  endtask

  task automatic test_stopwatch();
    do_reset();
    drive(B_MODE); drive(B_NONE);
    drive(B_SS);
    checks++; if (run_stopwatch !== 1'b1) begin failures++; $display("FAIL sw_start got=%b exp=1", run_stopwatch); end
    drive(B_NONE);
    drive(B_SET);
    checks++;
    if (clear_stopwatch !== 1'b0 || run_stopwatch !== 1'b1 || field_sel !== 3'b000) begin
      failures++; $display("FAIL sw_set_ignored got clr=%b rs=%b fs=%b exp 0 1 000", clear_stopwatch, run_stopwatch, field_sel);
    end
    drive(B_NONE);
    drive(B_SS);
    checks++; if (run_stopwatch !== 1'b0) begin failures++; $display("FAIL sw_stop got=%b exp=0", run_stopwatch); end
    drive(B_NONE);
    drive(B_SET);
    checks++; if (clear_stopwatch !== 1'b1) begin failures++; $display("FAIL sw_clear got=%b exp=1", clear_stopwatch); end
    drive(B_SET);
    checks++; if (clear_stopwatch !== 1'b0) begin failures++; $display("FAIL sw_clear_once got=%b exp=0", clear_stopwatch); end
    drive(B_NONE);
  endtask

  task automatic test_priority_and_reset();
    do_reset();
    drive(B_MODE); drive(B_NONE); drive(B_MODE); drive(B_NONE);
    drive(B_MODE | B_SET);
    checks++;
    if (field_sel !== 3'b100 || sel !== 2'b10) begin
      failures++; $display("FAIL same_cycle got fs=%b sel=%b exp fs=100 sel=10", field_sel, sel);
    end
    drive(B_NONE);
    drive(B_SET);
    checks++; if (field_sel !== 3'b010) begin failures++; $display("FAIL prio_set_min got=%b exp=010", field_sel); end
    drive(B_NONE);
    resetn = 1'b1; inc_b = 1'b1; step(); inc_b = 1'b0; resetn = 1'b0;
    checks++; if (dut_vec() !== RESET_VEC) begin failures++; $display("FAIL reset_mid_set got=%h exp=%h", dut_vec(), RESET_VEC); end
    step();
    checks++; if (dut_vec() !== RESET_VEC) begin failures++; $display("FAIL reset_mid_set_after got=%h exp=%h", dut_vec(), RESET_VEC); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      resetn = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 5) == 0) mode_b = ~mode_b;
      if ($urandom_range(0, 5) == 0) set_b  = ~set_b;
      if ($urandom_range(0, 5) == 0) inc_b  = ~inc_b;
      if ($urandom_range(0, 5) == 0) ss_b   = ~ss_b;
      if ($urandom_range(0, 19) == 0) tz    = ~tz;
      tick = ($urandom_range(0, 5) == 0);
      step();
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL random_c%0d got=%h exp=%h", c, dut_vec(), model_vec());
      end
    end
    resetn = 1'b0; tick = 1'b0;
  endtask

  initial begin
    resetn = 1'b1; tick = 1'b0; tz = 1'b0;
    mode_b = 1'b0; set_b = 1'b0; inc_b = 1'b0; ss_b = 1'b0;
    test_reset();
    test_mode_cycle();
    test_set_clock();
    test_timer_alarm();
    test_alarm_dismiss();
    test_stopwatch();
    test_priority_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mode_controller.md
Name: mode_controller

Overview:
- Control FSM for the clock/timer/stopwatch top.
- Owns the display-select code for the hour/min/sec output muxes and the run enables of the timer, stopwatch and 12/24-hour clocks.
- Routes debounced set/increment presses only to the selected function, sequences field-by-field setting, and handles timer-expiry alarm.
- Runs on the 100 MHz clock; uses a one-cycle 1 Hz tick as enable.

Parameters:
- ALARM_SECS, 10, number of 1 Hz ticks the alarm stays asserted before auto-dismiss (1..63).

Ports:
- clk_100MHz in 1 system clock.
- resetn in 1 synchronous reset, active-high (resetn=1 resets on next clk_100MHz edge).
- tick_1Hz in 1 single-cycle pulse, once per second.
- mode_btn in 1 debounced level; cycles display mode.
- set_btn in 1 debounced level; enters/advances set sequence.
- inc_btn in 1 debounced level; increments field being set.
- start_stop_btn in 1 debounced level; toggles run of timer/stopwatch.
- timer_zero in 1 level from timer: count is 00:00:00.
- sel out 2 mux select: 00 timer, 01 stopwatch, 10 clk12, 11 clk24.
- run_timer out 1 timer count-down enable.
- run_stopwatch out 1 stopwatch count-up enable.
- run_clock out 1 enable for both clock blocks.
- inc_hour, inc_min, inc_sec out 1 each; single-cycle increment pulses.
- inc_target out 2 mode code the inc pulses apply to (equals sel).
- clear_stopwatch out 1 single-cycle stopwatch clear.
- field_sel out 3 one-hot field being set {hour,min,sec}; 000 when not setting.
- alarm out 1 timer-expired indicator.

Behaviour:
- Reset values: sel=00, state=DISPLAY, run_timer=0, run_stopwatch=0, run_clock=1, all inc pulses=0, clear_stopwatch=0, field_sel=000, alarm=0, alarm_cnt=0, alarm_pending=0.
- Buttons:
  - Each button is registered; a press is btn=1 while its registered copy is 0.
  - Exactly one action per press, regardless of hold length.
  - All outputs are registered and change on the same edge that detects the press (1-cycle latency from the input being sampled high).
- Same-cycle priority: alarm entry > set_btn > start_stop_btn > mode_btn > inc_btn. Lower-priority presses in that cycle are discarded, not queued.
- States: DISPLAY, SET_HOUR, SET_MIN, SET_SEC, ALARM.
- DISPLAY:
  - mode_btn: sel <= sel+1, wrapping 11 -> 00.
  - start_stop_btn, sel=00: toggle run_timer. A start while timer_zero=1 is ignored.
  - start_stop_btn, sel=01: toggle run_stopwatch.
  - start_stop_btn, sel=1x: ignored.
  - set_btn, sel=00 with run_timer=0, or sel=1x: go to SET_HOUR.
  - set_btn, sel=01 with run_stopwatch=0: 1-cycle clear_stopwatch, stay in DISPLAY.
  - set_btn otherwise: ignored.
  - inc_btn: ignored.
- SET_HOUR / SET_MIN / SET_SEC:
  - field_sel = 100 / 010 / 001.
  - inc_btn: 1-cycle pulse on the matching inc_* output.
  - set_btn advances HOUR -> MIN -> SEC -> DISPLAY.
  - mode_btn and start_stop_btn are ignored.
  - run_clock=0 while setting with sel=1x; restored to 1 on return to DISPLAY.
  - Field wrap is the counter blocks' concern, not this block's.
- Timer expiry:
  - Condition: run_timer=1, timer_zero=1 and tick_1Hz=1 in the same cycle.
  - run_timer is cleared that edge.
  - In DISPLAY: enter ALARM that edge, alarm=1, alarm_cnt=0.
  - In a SET state: set alarm_pending. ALARM is entered on the edge that returns to DISPLAY, and alarm_pending is cleared.
- ALARM:
  - alarm=1; sel is unchanged; run_stopwatch and run_clock continue.
  - alarm_cnt increments on each tick_1Hz.
  - Dismiss when alarm_cnt reaches ALARM_SECS-1 with tick_1Hz=1, or on any button press. Dismiss goes to DISPLAY, alarm=0.
  - The dismissing press is consumed; it has no other effect.
- resetn=1 in any state, including mid-set or in ALARM: all registers return to reset values on that edge; pending pulses are dropped.

Decomposition:
- Package mode_ctrl_pkg holds:
  - mode codes MODE_TIMER=2'b00, MODE_STOPWATCH=2'b01, MODE_CLK12=2'b10, MODE_CLK24=2'b11.
  - FSM state encoding.
  - field_sel one-hot constants.
- Sub-module btn_edge: register plus rising-edge pulse with synchronous active-high reset; instantiated four times.

Test Plan:
- Reset, then four mode_btn presses -> sel 01, 10, 11, 00; run_clock=1 throughout.
- sel=10: set, inc, set, inc, inc, set -> one inc_hour pulse, two inc_min pulses, field_sel 100 -> 010 -> 001 -> 000; run_clock=0 while setting, then 1.
- sel=00: start_stop with timer_zero=0, then timer_zero=1 plus tick -> run_timer 1 then 0; alarm=1 for exactly 10 ticks, then DISPLAY.
- Alarm active, then mode_btn -> alarm=0 next edge; sel unchanged.
- sel=01: start_stop -> run_stopwatch=1; set is ignored; start_stop, then set -> run_stopwatch=0 and one clear_stopwatch pulse.
- mode_btn and set_btn in the same cycle, sel=10 -> SET_HOUR, sel stays 10; resetn mid-SET_MIN -> all outputs at reset values next edge.
